or_nway_accum: RTL

OR_NWAY_ACCUM -- requirements
Module: or_nway_accum

---
 rtl/or_nway_accum_if.sv | 39 +++
 rtl/or_nway_accum.sv | 123 ++++++++++++
 2 files changed

// File: rtl/or_nway_accum_if.sv
// Beat/result handshake bundle for the OR-accumulator; slave is the block's view, master the driver's.
// out_idx is only present when OR_NWAY_FIRST_IDX_EN is defined.
interface or_nway_accum_if #(
    parameter int WIDTH  = 8,
    parameter int BEAT_W = 4
);
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              acc_mode;
    logic              out;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_beats;

`ifdef OR_NWAY_FIRST_IDX_EN
    localparam int IDX_W = $clog2(WIDTH);
    logic [IDX_W-1:0]  out_idx;

    modport slave (
        input  in_data, in_valid, in_last, acc_mode, out_ready,
        output in_ready, out, out_valid, out_beats, out_idx
    );
    modport master (
        output in_data, in_valid, in_last, acc_mode, out_ready,
        input  in_ready, out, out_valid, out_beats, out_idx
    );
`else
    modport slave (
        input  in_data, in_valid, in_last, acc_mode, out_ready,
        output in_ready, out, out_valid, out_beats
    );
    modport master (
        output in_data, in_valid, in_last, acc_mode, out_ready,
        input  in_ready, out, out_valid, out_beats
    );
`endif
endinterface

// File: rtl/or_nway_accum.sv
// OR-reduces beats, singly or across in_last-terminated groups; result one cycle after the closing beat.
// in_ready = !out_valid | out_ready; optional first-set-bit index under OR_NWAY_FIRST_IDX_EN.
module or_nway_accum #(
    parameter int WIDTH  = 8,
    parameter int BEAT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    or_nway_accum_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [BEAT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic              acc_q, acc_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic              out_q, out_d;
    logic [BEAT_W-1:0] out_beats_q, out_beats_d;

    logic              beat_or;
    logic              in_ready;
    logic              accept;
    logic              closing;
    logic              out_valid_d;
    logic [BEAT_W-1:0] cnt_inc;

    always_comb begin
        beat_or  = |bus.in_data;
        // Ready is forced high in reset so upstream never stalls on a block that discards anyway.
        in_ready = !rst_n || (state_q != HOLD) || bus.out_ready;
        accept   = bus.in_valid && in_ready;
        closing  = accept && (!bus.acc_mode || bus.in_last);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_beats_d = out_beats_q;
        out_valid_d = (state_q == HOLD) && !bus.out_ready;

        if (closing) begin
            out_d       = acc_q | beat_or;
            out_beats_d = cnt_inc;
            acc_d       = 1'b0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
        end else if (accept) begin
            acc_d = acc_q | beat_or;
            cnt_d = cnt_inc;
        end

        // A partial group is recognisable by a nonzero count, since cnt saturates rather than wraps.
        if (out_valid_d) begin
            state_d = HOLD;
        end else if (cnt_d != '0) begin
            state_d = ACCUM;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_beats = out_beats_q;

`ifdef OR_NWAY_FIRST_IDX_EN
    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] beat_idx;

    function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) low_idx = IDX_W'(i);
        end
    endfunction

    always_comb begin
        beat_idx    = low_idx(bus.in_data);
        first_idx_d = first_idx_q;
        out_idx_d   = out_idx_q;
        // acc_q low means no nonzero beat yet, so this beat (if nonzero) is the first.
        if (closing) begin
            out_idx_d   = acc_q ? first_idx_q : beat_idx;
            first_idx_d = '0;
        end else if (accept && !acc_q) begin
            first_idx_d = beat_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_idx_q <= '0;
            out_idx_q   <= '0;
        end else begin
            first_idx_q <= first_idx_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.out_idx = out_idx_q;
`endif
endmodule
